// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : change_dispenser                                                |
// | Purpose  : Takes one change amount per transaction and pays it out coin by |
// |            coin (greedy 5/2/1) to a hopper, tracking per-coin stock and    |
// |            flagging a sticky fault on shortfall.                           |
// | Option   : DISPENSE_TIMEOUT_EN adds an ack-timeout fault in WAIT.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module change_dispenser #(
    parameter int STOCK5      = 10,
    parameter int STOCK2      = 10,
    parameter int STOCK1      = 10,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       change_valid,
    input  logic [3:0] change,
    output logic       change_ready,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    input  logic       coin_ack,
    output logic       done,
    output logic       fault,
    output logic       timeout,
    output logic [3:0] shortfall,
    output logic [2:0] states,
    output logic [7:0] stock5,
    output logic [7:0] stock2,
    output logic [7:0] stock1
);

    localparam logic [2:0] c_ST_IDLE   = 3'b000;
    localparam logic [2:0] c_ST_SELECT = 3'b001;
    localparam logic [2:0] c_ST_WAIT   = 3'b010;
    localparam logic [2:0] c_ST_DONE   = 3'b011;
    localparam logic [2:0] c_ST_FAULT  = 3'b100;

    localparam logic [1:0] c_SEL_1 = 2'b00;
    localparam logic [1:0] c_SEL_2 = 2'b01;
    localparam logic [1:0] c_SEL_5 = 2'b10;

    localparam logic [7:0] c_STOCK5_INIT = 8'(STOCK5);
    localparam logic [7:0] c_STOCK2_INIT = 8'(STOCK2);
    localparam logic [7:0] c_STOCK1_INIT = 8'(STOCK1);
    localparam logic [7:0] c_ACK_LIMIT   = 8'(ACK_TIMEOUT);

`ifdef DISPENSE_TIMEOUT_EN
    localparam logic c_TMO_EN = 1'b1;
`else
    localparam logic c_TMO_EN = 1'b0;
`endif

    logic [2:0] r_state,     w_state_nxt;
    logic [3:0] r_remaining, w_remaining_nxt;
    logic [1:0] r_coin_sel,  w_coin_sel_nxt;
    logic [7:0] r_stock5,    w_stock5_nxt;
    logic [7:0] r_stock2,    w_stock2_nxt;
    logic [7:0] r_stock1,    w_stock1_nxt;
    logic       r_fault,     w_fault_nxt;
    logic       r_timeout,   w_timeout_nxt;
    logic [3:0] r_shortfall, w_shortfall_nxt;
    logic [7:0] r_wait_cnt,  w_wait_cnt_nxt;

    logic [3:0] w_coin_val;
    logic [3:0] w_rem_after;
    logic       w_wait_expired;

    always_comb begin
        w_coin_val = 4'd1;
        case (r_coin_sel)
            c_SEL_5: w_coin_val = 4'd5;
            c_SEL_2: w_coin_val = 4'd2;
            default: w_coin_val = 4'd1;
        endcase
    end

    // Safe: a coin is only selected when its value does not exceed remaining.
    assign w_rem_after = r_remaining - w_coin_val;

    // Without the timeout option c_TMO_EN is 0, so WAIT never expires and the
    // counter never moves.
    assign w_wait_expired = c_TMO_EN && (r_wait_cnt == (c_ACK_LIMIT - 8'd1));

    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_coin_sel_nxt  = r_coin_sel;
        w_stock5_nxt    = r_stock5;
        w_stock2_nxt    = r_stock2;
        w_stock1_nxt    = r_stock1;
        w_fault_nxt     = r_fault;
        w_timeout_nxt   = r_timeout;
        w_shortfall_nxt = r_shortfall;
        w_wait_cnt_nxt  = r_wait_cnt;

        case (r_state)
            c_ST_IDLE: begin
                if (change_valid) begin
                    w_remaining_nxt = change;
                    w_state_nxt     = (change == 4'd0) ? c_ST_DONE : c_ST_SELECT;
                end
            end

            c_ST_SELECT: begin
                w_wait_cnt_nxt = 8'd0;
                if ((r_remaining >= 4'd5) && (r_stock5 != 8'd0)) begin
                    w_coin_sel_nxt = c_SEL_5;
                    w_state_nxt    = c_ST_WAIT;
                end else if ((r_remaining >= 4'd2) && (r_stock2 != 8'd0)) begin
                    w_coin_sel_nxt = c_SEL_2;
                    w_state_nxt    = c_ST_WAIT;
                end else if ((r_remaining >= 4'd1) && (r_stock1 != 8'd0)) begin
                    w_coin_sel_nxt = c_SEL_1;
                    w_state_nxt    = c_ST_WAIT;
                end else begin
                    w_shortfall_nxt = r_remaining;
                    w_fault_nxt     = 1'b1;
                    w_state_nxt     = c_ST_FAULT;
                end
            end

            c_ST_WAIT: begin
                if (coin_ack) begin
                    w_remaining_nxt = w_rem_after;
                    case (r_coin_sel)
                        c_SEL_5: w_stock5_nxt = r_stock5 - 8'd1;
                        c_SEL_2: w_stock2_nxt = r_stock2 - 8'd1;
                        default: w_stock1_nxt = r_stock1 - 8'd1;
                    endcase
                    w_state_nxt = (w_rem_after == 4'd0) ? c_ST_DONE : c_ST_SELECT;
                end else if (w_wait_expired) begin
                    w_fault_nxt     = 1'b1;
                    w_timeout_nxt   = 1'b1;
                    w_shortfall_nxt = r_remaining;
                    w_state_nxt     = c_ST_FAULT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + {7'd0, c_TMO_EN};
                end
            end

            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end

            c_ST_FAULT: begin
                w_state_nxt = c_ST_FAULT;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_remaining <= 4'd0;
            r_coin_sel  <= c_SEL_1;
            r_stock5    <= c_STOCK5_INIT;
            r_stock2    <= c_STOCK2_INIT;
            r_stock1    <= c_STOCK1_INIT;
            r_fault     <= 1'b0;
            r_timeout   <= 1'b0;
            r_shortfall <= 4'd0;
            r_wait_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
            r_coin_sel  <= w_coin_sel_nxt;
            r_stock5    <= w_stock5_nxt;
            r_stock2    <= w_stock2_nxt;
            r_stock1    <= w_stock1_nxt;
            r_fault     <= w_fault_nxt;
            r_timeout   <= w_timeout_nxt;
            r_shortfall <= w_shortfall_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
        end
    end

    assign change_ready = (r_state == c_ST_IDLE);
    assign coin_req     = (r_state == c_ST_WAIT);
    assign done         = (r_state == c_ST_DONE);
    assign coin_sel     = r_coin_sel;
    assign fault        = r_fault;
    assign timeout      = r_timeout;
    assign shortfall    = r_shortfall;
    assign states       = r_state;
    assign stock5       = r_stock5;
    assign stock2       = r_stock2;
    assign stock1       = r_stock1;

endmodule

`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_change_dispenser                                             |
// | Purpose  : Bench for change_dispenser: three stock configurations, a       |
// |            transaction-level model, a per-cycle compare and literal pins.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_change_dispenser;

    localparam int c_N      = 3;
    localparam int c_ACK_TO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid [c_N];
    logic [3:0] change       [c_N];
    logic       coin_ack     [c_N];
    logic       change_ready [c_N];
    logic       coin_req     [c_N];
    logic [1:0] coin_sel     [c_N];
    logic       done         [c_N];
    logic       fault        [c_N];
    logic       timeout      [c_N];
    logic [3:0] shortfall    [c_N];
    logic [2:0] states       [c_N];
    logic [7:0] stock5       [c_N];
    logic [7:0] stock2       [c_N];
    logic [7:0] stock1       [c_N];

    always #5 clk = ~clk;

    // Instance 0: default stock, 1: no fives, 2: a single five and nothing else.
    for (genvar g = 0; g < c_N; g++) begin : g_dut
        localparam int P5 = (g == 2) ? 1 : ((g == 1) ? 0 : 10);
        localparam int P2 = (g == 2) ? 0 : 10;
        localparam int P1 = (g == 2) ? 0 : 10;
        change_dispenser #(
            .STOCK5(P5), .STOCK2(P2), .STOCK1(P1), .ACK_TIMEOUT(c_ACK_TO)
        ) u_dut (
            .clk(clk), .reset(reset),
            .change_valid(change_valid[g]), .change(change[g]),
            .change_ready(change_ready[g]), .coin_req(coin_req[g]),
            .coin_sel(coin_sel[g]), .coin_ack(coin_ack[g]),
            .done(done[g]), .fault(fault[g]), .timeout(timeout[g]),
            .shortfall(shortfall[g]), .states(states[g]),
            .stock5(stock5[g]), .stock2(stock2[g]), .stock1(stock1[g])
        );
    end

    int nvec = 0;
    int nerr = 0;
    int cur  = 0;
    int log_q[$];

    // inputs as seen by the DUT at the last rising edge
    logic       cap_reset;
    logic       cap_valid [c_N];
    logic [3:0] cap_change[c_N];
    logic       cap_ack   [c_N];

    always @(posedge clk) begin
        cap_reset <= reset;
        for (int d = 0; d < c_N; d++) begin
            cap_valid[d]  <= change_valid[d];
            cap_change[d] <= change[d];
            cap_ack[d]    <= coin_ack[d];
        end
    end

    // transaction-level model
    int ms5[c_N], ms2[c_N], ms1[c_N];
    int mbusy[c_N], msel[c_N], mreq[c_N], mcoin[c_N], mrem[c_N];
    int mdone[c_N], mfault[c_N], mtmo[c_N], mshort[c_N], mwait[c_N];
    int prev_req[c_N];

    task automatic chk(string name, int d, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int init_stock(int d, int v);
        if (d == 2) return (v == 5) ? 1 : 0;
        if (d == 1 && v == 5) return 0;
        return 10;
    endfunction

    function automatic int greedy(int d);
        if (mrem[d] >= 5 && ms5[d] > 0) return 5;
        if (mrem[d] >= 2 && ms2[d] > 0) return 2;
        if (mrem[d] >= 1 && ms1[d] > 0) return 1;
        return 0;
    endfunction

    function automatic int sel_code(int v);
        return (v == 5) ? 2 : ((v == 2) ? 1 : 0);
    endfunction

    function automatic int sel_value(logic [1:0] s);
        return (s == 2'b10) ? 5 : ((s == 2'b01) ? 2 : ((s == 2'b00) ? 1 : 15));
    endfunction

    task automatic model_step(int d);
        int v;
        if (cap_reset) begin
            ms5[d] = init_stock(d, 5); ms2[d] = init_stock(d, 2); ms1[d] = init_stock(d, 1);
            mbusy[d] = 0; msel[d] = 0; mreq[d] = 0; mcoin[d] = 0; mrem[d] = 0;
            mdone[d] = 0; mfault[d] = 0; mtmo[d] = 0; mshort[d] = 0; mwait[d] = 0;
        end else if (mfault[d] != 0) begin
            mdone[d] = 0;
        end else if (mdone[d] != 0) begin
            mdone[d] = 0;
            mbusy[d] = 0;
        end else if (msel[d] != 0) begin
            msel[d] = 0;
            v = greedy(d);
            if (v != 0) begin
                mreq[d] = 1; mcoin[d] = v; mwait[d] = 0;
            end else begin
                mfault[d] = 1; mshort[d] = mrem[d];
            end
        end else if (mreq[d] != 0) begin
            if (cap_ack[d] === 1'b1) begin
                mreq[d] = 0;
                if (mcoin[d] == 5) ms5[d]--;
                else if (mcoin[d] == 2) ms2[d]--;
                else ms1[d]--;
                mrem[d] -= mcoin[d];
                if (mrem[d] == 0) mdone[d] = 1;
                else msel[d] = 1;
            end else begin
`ifdef DISPENSE_TIMEOUT_EN
                mwait[d]++;
                if (mwait[d] == c_ACK_TO) begin
                    mreq[d] = 0; mfault[d] = 1; mtmo[d] = 1; mshort[d] = mrem[d];
                end
`endif
            end
        end else if (cap_valid[d] === 1'b1) begin
            mbusy[d] = 1;
            mrem[d]  = int'(cap_change[d]);
            if (mrem[d] == 0) mdone[d] = 1;
            else msel[d] = 1;
        end
    endtask

    task automatic check_dut(int d);
        int exp_state;
        exp_state = (mfault[d] != 0) ? 4 : (mdone[d] != 0) ? 3 :
                    (mreq[d] != 0) ? 2 : (msel[d] != 0) ? 1 : 0;
        chk("states", d, int'(states[d]), exp_state);
        chk("change_ready", d, int'(change_ready[d]), int'(mbusy[d] == 0 && mfault[d] == 0));
        chk("coin_req", d, int'(coin_req[d]), mreq[d]);
        if (mreq[d] != 0) chk("coin_sel", d, int'(coin_sel[d]), sel_code(mcoin[d]));
        chk("done", d, int'(done[d]), mdone[d]);
        chk("fault", d, int'(fault[d]), mfault[d]);
        chk("timeout", d, int'(timeout[d]), mtmo[d]);
        chk("shortfall", d, int'(shortfall[d]), (mfault[d] != 0) ? mshort[d] : 0);
        chk("stock5", d, int'(stock5[d]), ms5[d]);
        chk("stock2", d, int'(stock2[d]), ms2[d]);
        chk("stock1", d, int'(stock1[d]), ms1[d]);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < c_N; d++) begin
                model_step(d);
                check_dut(d);
                if (d == cur && coin_req[d] === 1'b1 && prev_req[d] == 0)
                    log_q.push_back(sel_value(coin_sel[d]));
                prev_req[d] = (coin_req[d] === 1'b1) ? 1 : 0;
            end
        end
    end

    // hopper: acks ack_dly cycles after a request; otherwise follows force_ack
    int hop_en[c_N];
    int force_ack[c_N];
    int hcnt[c_N];
    int ack_dly = 2;

    initial begin
        for (int d = 0; d < c_N; d++) begin
            coin_ack[d] = 1'b0; hcnt[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < c_N; d++) begin
                if (hop_en[d] == 0) begin
                    coin_ack[d] = (force_ack[d] != 0);
                    hcnt[d] = 0;
                end else if (coin_ack[d]) begin
                    coin_ack[d] = 1'b0;
                    hcnt[d] = 0;
                end else if (coin_req[d] === 1'b1) begin
                    hcnt[d]++;
                    if (hcnt[d] >= ack_dly) coin_ack[d] = 1'b1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        log_q.delete();
    endtask

    task automatic send(int d, int amt);
        @(negedge clk);
        change_valid[d] = 1'b1;
        change[d] = 4'(amt);
        @(negedge clk);
        change_valid[d] = 1'b0;
    endtask

    task automatic wait_end(int d, int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done[d] === 1'b1 || fault[d] === 1'b1) begin
                ok = 1;
                break;
            end
        end
        chk("wait_bound", d, ok, 1);
    endtask

    task automatic check_log(int n, int a0, int a1, int a2, int a3);
        int e[4];
        e = '{a0, a1, a2, a3};
        chk("coin_count", cur, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            chk("coin_value", cur, log_q[i], e[i]);
    endtask

    initial begin
        int ok;
        reset = 1'b1;
        for (int d = 0; d < c_N; d++) begin
            change_valid[d] = 1'b0; change[d] = 4'd0; hop_en[d] = 0; force_ack[d] = 0;
            prev_req[d] = 0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: change 10 -> 5,5
        cur = 0; do_reset(); hop_en[0] = 1;
        send(0, 10); wait_end(0, 200);
        chk("t1_stock5", 0, int'(stock5[0]), 8);
        @(negedge clk);
        chk("t1_ready_back", 0, int'(change_ready[0]), 1);
        check_log(2, 5, 5, 0, 0);

        // 2: change 9 -> 5,2,2
        do_reset();
        send(0, 9); wait_end(0, 200);
        chk("t2_stock5", 0, int'(stock5[0]), 9);
        chk("t2_stock2", 0, int'(stock2[0]), 8);
        chk("t2_stock1", 0, int'(stock1[0]), 10);
        check_log(3, 5, 2, 2, 0);

        // 3: no fives, change 7 -> 2,2,2,1
        cur = 1; do_reset(); hop_en[1] = 1;
        send(1, 7); wait_end(1, 200);
        chk("t3_stock2", 1, int'(stock2[1]), 7);
        chk("t3_stock1", 1, int'(stock1[1]), 9);
        check_log(4, 2, 2, 2, 1);

        // 4: one five only, change 6 -> 5 then shortfall 1
        cur = 2; do_reset(); hop_en[2] = 1;
        send(2, 6); wait_end(2, 200);
        chk("t4_fault", 2, int'(fault[2]), 1);
        chk("t4_shortfall", 2, int'(shortfall[2]), 1);
        chk("t4_states", 2, int'(states[2]), 4);
        check_log(1, 5, 0, 0, 0);
        send(2, 3);
        repeat (3) @(negedge clk);
        chk("t4_still_fault", 2, int'(states[2]), 4);
        chk("t4_ready_low", 2, int'(change_ready[2]), 0);

        // 5: zero change, then a stray ack in IDLE
        cur = 0; hop_en[0] = 0; do_reset();
        send(0, 0);
        chk("t5_done", 0, int'(done[0]), 1);
        @(negedge clk);
        chk("t5_done_drop", 0, int'(done[0]), 0);
        check_log(0, 0, 0, 0, 0);
        force_ack[0] = 1;
        repeat (2) @(negedge clk);
        force_ack[0] = 0;
        repeat (3) @(negedge clk);
        chk("t5_stock5", 0, int'(stock5[0]), 10);
        chk("t5_stock1", 0, int'(stock1[0]), 10);

        // 6: reset while waiting for the second coin's ack
        do_reset(); hop_en[0] = 1;
        send(0, 10);
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (stock5[0] == 8'd9) ok = 1;
        end
        chk("t6_first_coin", 0, ok, 1);
        hop_en[0] = 0;
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (coin_req[0] === 1'b1) ok = 1;
        end
        chk("t6_second_req", 0, ok, 1);
        do_reset();
        chk("t6_req_low", 0, int'(coin_req[0]), 0);
        chk("t6_idle", 0, int'(states[0]), 0);
        chk("t6_stock5", 0, int'(stock5[0]), 10);

`ifdef DISPENSE_TIMEOUT_EN
        do_reset();
        send(0, 7); wait_end(0, 60);
        chk("t6_timeout", 0, int'(timeout[0]), 1);
        chk("t6_tmo_fault", 0, int'(fault[0]), 1);
        chk("t6_tmo_short", 0, int'(shortfall[0]), 7);
        chk("t6_tmo_stock5", 0, int'(stock5[0]), 10);
`else
        do_reset();
        send(0, 7);
        repeat (40) @(negedge clk);
        chk("t6_no_timeout", 0, int'(timeout[0]), 0);
        chk("t6_still_wait", 0, int'(coin_req[0]), 1);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d vectors applied", nvec);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
